// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised coin-accumulating vending controller with streamed change
//
// Accumulates coins (10c units) until credit >= PRICE, pulses goods for one cycle,
// then pays out the remainder as greedy change beats over a valid/ready link.
//
// Parameters:
//   PRICE     item price in 10c units (1..31)
//   CREDIT_W  credit/change width, must hold PRICE+4
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   coin_vld, coin_val  coin strobe and denomination (0=10c 1=20c 2=50c 3=invalid)
//   cancel              refund request (used only with VEND_CANCEL_EN)
//   coin_rej            1-cycle pulse, previous coin strobe not accepted
//   goods               1-cycle dispense pulse
//   chg_vld, chg_coin   change beat and its denomination (coin_val encoding)
//   chg_rdy             hopper accepts the current beat
//   credit              accumulated credit, or remaining change once vending
//   busy                high while vending or paying change
//
// Optional feature macro: VEND_CANCEL_EN (refund of collected credit on cancel).

module vend_ctrl_param #(
  parameter int PRICE    = 6,
  parameter int CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_vld,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  output logic                coin_rej,
  output logic                goods,
  output logic                chg_vld,
  output logic [1:0]          chg_coin,
  input  logic                chg_rdy,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (PRICE < 1 || PRICE > 31) begin : g_bad_price
    $error("vend_ctrl_param: PRICE must be in 1..31");
  end
  if ((PRICE + 4) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vend_ctrl_param: CREDIT_W cannot hold PRICE+4");
  end

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  function automatic logic [CREDIT_W-1:0] coin_amt(input logic [1:0] code);
    case (code)
      2'd0:    coin_amt = CREDIT_W'(1);
      2'd1:    coin_amt = CREDIT_W'(2);
      2'd2:    coin_amt = CREDIT_W'(5);
      default: coin_amt = '0;
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                rej_q, rej_d;
  logic                coin_ok;
  logic [CREDIT_W-1:0] sum;
  logic [1:0]          greedy;

  assign busy    = (state_q == S_VEND) || (state_q == S_CHANGE);
  assign goods   = (state_q == S_VEND);
  assign chg_vld = (state_q == S_CHANGE);
  assign credit  = credit_q;
  assign coin_rej = rej_q;

  // Denomination follows the remaining credit only, which moves solely on a
  // completed handshake, so the beat stays stable while the hopper stalls.
  always_comb begin
    greedy = 2'd0;
    if (credit_q >= CREDIT_W'(5))      greedy = 2'd2;
    else if (credit_q >= CREDIT_W'(2)) greedy = 2'd1;
  end
  assign chg_coin = chg_vld ? greedy : 2'd0;

  assign coin_ok = coin_vld && (coin_val != 2'd3) && !busy;
  assign sum     = credit_q + coin_amt(coin_val);

`ifndef VEND_CANCEL_EN
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    rej_d    = coin_vld && !coin_ok;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (coin_ok) begin
          if (sum >= PRICE_C) begin
            // Credit switches to the remaining change as VEND is entered.
            credit_d = sum - PRICE_C;
            state_d  = S_VEND;
          end else begin
            credit_d = sum;
            state_d  = S_COLLECT;
          end
        end
`ifdef VEND_CANCEL_EN
        // Cancel overrides a vend: a coin on the same edge is added, then the
        // whole new credit is refunded.
        if (state_q == S_COLLECT && cancel) begin
          credit_d = coin_ok ? sum : credit_q;
          state_d  = S_CHANGE;
        end
`endif
      end
      S_VEND: begin
        state_d = (credit_q == '0) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        if (chg_rdy) begin
          credit_d = credit_q - coin_amt(greedy);
          if (credit_d == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      rej_q    <= rej_d;
    end
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - scoreboard testbench for vend_ctrl_param

module tb_vend_ctrl_param;

  localparam int PRICE    = 6;
  localparam int CREDIT_W = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                coin_vld = 1'b0;
  logic [1:0]          coin_val = 2'd0;
  logic                cancel = 1'b0;
  logic                chg_rdy = 1'b1;
  logic                coin_rej, goods, chg_vld, busy;
  logic [1:0]          chg_coin;
  logic [CREDIT_W-1:0] credit;

  int n_cmp = 0;
  int n_err = 0;
  int exp_beats[$];
  int goods_pend = 0;
  logic       stall_q = 1'b0;
  logic [1:0] stall_coin = 2'd0;

  vend_ctrl_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
    .clk(clk), .rst_n(rst_n), .coin_vld(coin_vld), .coin_val(coin_val),
    .cancel(cancel), .coin_rej(coin_rej), .goods(goods), .chg_vld(chg_vld),
    .chg_coin(chg_coin), .chg_rdy(chg_rdy), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected sale: one goods pulse plus greedy change beats for the remainder.
  task automatic push_sale(input int sum);
    int rem;
    goods_pend++;
    rem = sum - PRICE;
    while (rem > 0) begin
      if (rem >= 5)      begin exp_beats.push_back(2); rem -= 5; end
      else if (rem >= 2) begin exp_beats.push_back(1); rem -= 2; end
      else               begin exp_beats.push_back(0); rem -= 1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert_coin(input logic [1:0] v);
    coin_vld = 1'b1;
    coin_val = v;
    step();
    coin_vld = 1'b0;
    coin_val = 2'd0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      step();
    end
    check_eq({tag, "_idle"}, busy, 0);
    check_eq({tag, "_beats_left"}, exp_beats.size(), 0);
    check_eq({tag, "_goods_left"}, goods_pend, 0);
    check_eq({tag, "_credit_end"}, credit, 0);
  endtask

  // Output side of the scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (goods) begin
        check_eq("goods_expected", goods_pend > 0, 1);
        if (goods_pend > 0) goods_pend--;
      end
      if (chg_vld && stall_q) check_eq("chg_stable", chg_coin, stall_coin);
      if (chg_vld && chg_rdy) begin
        if (exp_beats.size() == 0) check_eq("beat_unexpected", chg_coin, 3);
        else check_eq("beat_coin", chg_coin, exp_beats.pop_front());
      end
      stall_q    <= chg_vld && !chg_rdy;
      stall_coin <= chg_coin;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_eq("rst_credit", credit, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_goods", goods, 0);
    check_eq("rst_chg_vld", chg_vld, 0);
    check_eq("rst_chg_coin", chg_coin, 0);
    check_eq("rst_coin_rej", coin_rej, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 10c, 20c, 50c -> goods right after the 50c edge, one 20c beat
    insert_coin(2'd0);
    check_eq("t2_credit1", credit, 1);
    insert_coin(2'd1);
    check_eq("t2_credit3", credit, 3);
    push_sale(8);
    insert_coin(2'd2);
    check_eq("t2_goods_lat", goods, 1);
    check_eq("t2_credit_rem", credit, 2);
    wait_idle("t2");

    // 50c, 50c -> beats 20c, 20c with the hopper stalled for 3 cycles
    chg_rdy = 1'b0;
    insert_coin(2'd2);
    check_eq("t3_credit5", credit, 5);
    push_sale(10);
    insert_coin(2'd2);
    check_eq("t3_goods", goods, 1);
    check_eq("t3_credit_rem", credit, 4);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t3_stall_vld", chg_vld, 1);
      check_eq("t3_stall_coin", chg_coin, 1);
    end
    chg_rdy = 1'b1;
    wait_idle("t3");

    // 20c x3 -> exact price, no change; then an invalid coin
    insert_coin(2'd1);
    insert_coin(2'd1);
    check_eq("t4_credit4", credit, 4);
    push_sale(6);
    insert_coin(2'd1);
    check_eq("t4_goods", goods, 1);
    check_eq("t4_credit0", credit, 0);
    step();
    check_eq("t4_no_chg", chg_vld, 0);
    check_eq("t4_busy", busy, 0);
    insert_coin(2'd3);
    check_eq("t4_rej", coin_rej, 1);
    check_eq("t4_rej_credit", credit, 0);
    step();
    check_eq("t4_rej_pulse", coin_rej, 0);
    wait_idle("t4");

    // 50c, 20c, then 10c during CHANGE -> rejected, single 10c beat
    chg_rdy = 1'b0;
    insert_coin(2'd2);
    push_sale(7);
    insert_coin(2'd1);
    check_eq("t5_goods", goods, 1);
    step();
    check_eq("t5_chg_vld", chg_vld, 1);
    insert_coin(2'd0);
    check_eq("t5_rej", coin_rej, 1);
    check_eq("t5_credit", credit, 1);
    chg_rdy = 1'b1;
    wait_idle("t5");

    // reset asserted mid-CHANGE
    chg_rdy = 1'b0;
    insert_coin(2'd2);
    push_sale(10);
    insert_coin(2'd2);
    step();
    check_eq("t1_in_change", chg_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_chg_vld", chg_vld, 0);
    check_eq("t1_chg_coin", chg_coin, 0);
    check_eq("t1_goods", goods, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_credit", credit, 0);
    check_eq("t1_coin_rej", coin_rej, 0);
    exp_beats.delete();
    step();
    rst_n = 1'b1;
    chg_rdy = 1'b1;
    step();
    wait_idle("t1");

`ifdef VEND_CANCEL_EN
    // 50c then cancel -> no goods, single 50c refund beat
    insert_coin(2'd2);
    exp_beats.push_back(2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_eq("t6_goods", goods, 0);
    check_eq("t6_chg_vld", chg_vld, 1);
    check_eq("t6_chg_coin", chg_coin, 2);
    wait_idle("t6");
    // coin and cancel together: 20c + 50c refunded as 50c, 20c
    insert_coin(2'd1);
    exp_beats.push_back(2);
    exp_beats.push_back(1);
    cancel = 1'b1;
    insert_coin(2'd2);
    cancel = 1'b0;
    check_eq("t6b_goods", goods, 0);
    check_eq("t6b_credit", credit, 7);
    wait_idle("t6b");
`else
    // cancel has no effect in the default build
    insert_coin(2'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_credit", credit, 2);
    push_sale(6);
    insert_coin(2'd1);
    insert_coin(2'd1);
    check_eq("t6_goods", goods, 1);
    wait_idle("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
